// File: rtl/reorder_buffer.sv
// Circular in-order completion buffer: hands out ROB tags, resolves issue operands,
// snoops both CDB ports and retires in program order, raising flush on mispredict.
module reorder_buffer #(
  parameter int unsigned ROB_ID_WIDTH = 3,
  parameter int unsigned VAL_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned OP_WIDTH     = 6,
  parameter logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(1),
  parameter logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(2)
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    dec2rob_en,
  input  logic [OP_WIDTH-1:0]     op_type,
  input  logic [4:0]              rd,
  input  logic [ADDR_WIDTH-1:0]   nowPC,
  input  logic [ADDR_WIDTH-1:0]   jumpAddr,
  input  logic                    predTaken,
  input  logic [ROB_ID_WIDTH:0]   rf_lab1,
  input  logic [ROB_ID_WIDTH:0]   rf_lab2,
  input  logic [VAL_WIDTH-1:0]    rf_val1,
  input  logic [VAL_WIDTH-1:0]    rf_val2,
  output logic [ROB_ID_WIDTH:0]   label1,
  output logic [ROB_ID_WIDTH:0]   label2,
  output logic [VAL_WIDTH-1:0]    res1,
  output logic [VAL_WIDTH-1:0]    res2,
  output logic                    ready1,
  output logic                    ready2,
  output logic [ROB_ID_WIDTH:0]   newTag,
  output logic                    isFull,
  input  logic                    rs_cdbReady,
  input  logic                    lsb_cdbReady,
  input  logic [ROB_ID_WIDTH:0]   rs_cdb2lab,
  input  logic [ROB_ID_WIDTH:0]   lsb_cdb2lab,
  input  logic [VAL_WIDTH-1:0]    rs_cdb2val,
  input  logic [VAL_WIDTH-1:0]    lsb_cdb2val,
  output logic                    rob2rf_en,
  output logic [4:0]              rob2rf_rd,
  output logic [VAL_WIDTH-1:0]    rob2rf_val,
  output logic [ROB_ID_WIDTH:0]   rob2rf_tag,
  output logic                    rob2lsb_store,
  output logic [ROB_ID_WIDTH:0]   rob2lsb_tag,
  output logic                    flush,
  output logic [ADDR_WIDTH-1:0]   rob2if_pc
);
  localparam int unsigned ROB_SIZE = 1 << ROB_ID_WIDTH;
  localparam int unsigned TAG_W    = ROB_ID_WIDTH + 1;

  logic [ROB_SIZE-1:0]     busy_q;
  logic [ROB_SIZE-1:0]     ready_q;
  logic [ROB_SIZE-1:0]     pred_q;
  logic [OP_WIDTH-1:0]     op_q   [ROB_SIZE];
  logic [4:0]              rd_q   [ROB_SIZE];
  logic [VAL_WIDTH-1:0]    val_q  [ROB_SIZE];
  logic [ADDR_WIDTH-1:0]   pc_q   [ROB_SIZE];
  logic [ADDR_WIDTH-1:0]   jump_q [ROB_SIZE];
  logic [ROB_ID_WIDTH-1:0] head_q;
  logic [ROB_ID_WIDTH-1:0] tail_q;
  logic [TAG_W-1:0]        count_q;
  logic                    clr_pend_q;

  logic [ROB_ID_WIDTH-1:0] slot1, slot2, rs_slot, lsb_slot;
  logic [TAG_W-1:0]        head_tag;
  logic                    do_issue, do_commit, actual_taken;

  // tag = slot + 1, so tag 0 is free to mean "no producer"
  assign slot1    = ROB_ID_WIDTH'(rf_lab1 - TAG_W'(1));
  assign slot2    = ROB_ID_WIDTH'(rf_lab2 - TAG_W'(1));
  assign rs_slot  = ROB_ID_WIDTH'(rs_cdb2lab - TAG_W'(1));
  assign lsb_slot = ROB_ID_WIDTH'(lsb_cdb2lab - TAG_W'(1));
  assign head_tag = TAG_W'(head_q) + TAG_W'(1);

  assign isFull  = (count_q == TAG_W'(ROB_SIZE));
  assign newTag  = TAG_W'(tail_q) + TAG_W'(1);
  assign label1  = rf_lab1;
  assign label2  = rf_lab2;

  // a pending flush-clear freezes issue and retirement until the buffer is wiped
  assign do_issue     = dec2rob_en && !isFull && !clr_pend_q;
  assign do_commit    = !clr_pend_q && busy_q[head_q] && ready_q[head_q];
  assign actual_taken = val_q[head_q][0];

  // operand 1: committed value, finished entry, or same-cycle CDB bypass
  always_comb begin
    ready1 = 1'b1;
    res1   = rf_val1;
    if (rf_lab1 != '0) begin
      if (ready_q[slot1])                                 res1 = val_q[slot1];
      else if (rs_cdbReady && (rs_cdb2lab == rf_lab1))    res1 = rs_cdb2val;
      else if (lsb_cdbReady && (lsb_cdb2lab == rf_lab1))  res1 = lsb_cdb2val;
      else begin
        ready1 = 1'b0;
        res1   = '0;
      end
    end
  end

  always_comb begin
    ready2 = 1'b1;
    res2   = rf_val2;
    if (rf_lab2 != '0) begin
      if (ready_q[slot2])                                 res2 = val_q[slot2];
      else if (rs_cdbReady && (rs_cdb2lab == rf_lab2))    res2 = rs_cdb2val;
      else if (lsb_cdbReady && (lsb_cdb2lab == rf_lab2))  res2 = lsb_cdb2val;
      else begin
        ready2 = 1'b0;
        res2   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      busy_q        <= '0;
      ready_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      clr_pend_q    <= 1'b0;
      rob2rf_en     <= 1'b0;
      rob2rf_rd     <= '0;
      rob2rf_val    <= '0;
      rob2rf_tag    <= '0;
      rob2lsb_store <= 1'b0;
      rob2lsb_tag   <= '0;
      flush         <= 1'b0;
      rob2if_pc     <= '0;
    end else begin
      rob2rf_en     <= 1'b0;
      rob2lsb_store <= 1'b0;
      flush         <= 1'b0;
      if (rdy_in) begin
        if (clr_pend_q) begin
          busy_q     <= '0;
          ready_q    <= '0;
          head_q     <= '0;
          tail_q     <= '0;
          count_q    <= '0;
          clr_pend_q <= 1'b0;
          rob2if_pc  <= '0;
        end else begin
          if (rs_cdbReady && (rs_cdb2lab != '0) && busy_q[rs_slot]) begin
            ready_q[rs_slot] <= 1'b1;
            val_q[rs_slot]   <= rs_cdb2val;
          end
          if (lsb_cdbReady && (lsb_cdb2lab != '0) && busy_q[lsb_slot]) begin
            ready_q[lsb_slot] <= 1'b1;
            val_q[lsb_slot]   <= lsb_cdb2val;
          end
          if (do_issue) begin
            busy_q[tail_q]  <= 1'b1;
            ready_q[tail_q] <= 1'b0;
            op_q[tail_q]    <= op_type;
            rd_q[tail_q]    <= rd;
            pc_q[tail_q]    <= nowPC;
            jump_q[tail_q]  <= jumpAddr;
            pred_q[tail_q]  <= predTaken;
            tail_q          <= tail_q + ROB_ID_WIDTH'(1);
          end
          if (do_commit) begin
            busy_q[head_q]  <= 1'b0;
            ready_q[head_q] <= 1'b0;
            head_q          <= head_q + ROB_ID_WIDTH'(1);
            if (op_q[head_q] == OP_BRANCH) begin
              if (actual_taken != pred_q[head_q]) begin
                flush      <= 1'b1;
                clr_pend_q <= 1'b1;
                rob2if_pc  <= actual_taken ? jump_q[head_q] : pc_q[head_q] + ADDR_WIDTH'(4);
              end
            end else if (op_q[head_q] == OP_STORE) begin
              rob2lsb_store <= 1'b1;
              rob2lsb_tag   <= head_tag;
            end else begin
              rob2rf_en  <= 1'b1;
              rob2rf_rd  <= rd_q[head_q];
              rob2rf_val <= val_q[head_q];
              rob2rf_tag <= head_tag;
            end
          end
          count_q <= count_q + TAG_W'(do_issue) - TAG_W'(do_commit);
        end
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, all checked
// against an in-order queue model of the buffer.
module tb_reorder_buffer;
  localparam int unsigned IDW = 3;
  localparam int unsigned VW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned OW  = 6;
  localparam int unsigned TW  = IDW + 1;
  localparam int unsigned N   = 8;
  localparam logic [OW-1:0] OP_ALU = 6'd0;
  localparam logic [OW-1:0] OP_BR  = 6'd1;
  localparam logic [OW-1:0] OP_ST  = 6'd2;

  logic clk = 1'b0;
  logic rst_in, rdy_in, dec2rob_en, predTaken;
  logic [OW-1:0] op_type;
  logic [4:0] rd;
  logic [AW-1:0] nowPC, jumpAddr;
  logic [TW-1:0] rf_lab1, rf_lab2, label1, label2, newTag;
  logic [VW-1:0] rf_val1, rf_val2, res1, res2;
  logic ready1, ready2, isFull;
  logic rs_cdbReady, lsb_cdbReady;
  logic [TW-1:0] rs_cdb2lab, lsb_cdb2lab;
  logic [VW-1:0] rs_cdb2val, lsb_cdb2val;
  logic rob2rf_en, rob2lsb_store, flush;
  logic [4:0] rob2rf_rd;
  logic [VW-1:0] rob2rf_val;
  logic [TW-1:0] rob2rf_tag, rob2lsb_tag;
  logic [AW-1:0] rob2if_pc;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_ID_WIDTH(IDW), .VAL_WIDTH(VW), .ADDR_WIDTH(AW), .OP_WIDTH(OW),
                   .OP_BRANCH(OP_BR), .OP_STORE(OP_ST)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .dec2rob_en(dec2rob_en),
    .op_type(op_type), .rd(rd), .nowPC(nowPC), .jumpAddr(jumpAddr), .predTaken(predTaken),
    .rf_lab1(rf_lab1), .rf_lab2(rf_lab2), .rf_val1(rf_val1), .rf_val2(rf_val2),
    .label1(label1), .label2(label2), .res1(res1), .res2(res2),
    .ready1(ready1), .ready2(ready2), .newTag(newTag), .isFull(isFull),
    .rs_cdbReady(rs_cdbReady), .lsb_cdbReady(lsb_cdbReady),
    .rs_cdb2lab(rs_cdb2lab), .lsb_cdb2lab(lsb_cdb2lab),
    .rs_cdb2val(rs_cdb2val), .lsb_cdb2val(lsb_cdb2val),
    .rob2rf_en(rob2rf_en), .rob2rf_rd(rob2rf_rd), .rob2rf_val(rob2rf_val), .rob2rf_tag(rob2rf_tag),
    .rob2lsb_store(rob2lsb_store), .rob2lsb_tag(rob2lsb_tag),
    .flush(flush), .rob2if_pc(rob2if_pc)
  );

  // reference model: program-ordered list of in-flight instructions
  typedef struct {
    int            tag;
    bit            rdy;
    logic [VW-1:0] val;
    logic [OW-1:0] op;
    logic [4:0]    rd;
    logic [AW-1:0] pc;
    logic [AW-1:0] jmp;
    bit            pred;
  } ent_t;

  ent_t mq[$];
  int   m_next = 1;
  bit   m_clr  = 0;
  logic          e_rf_en = 0, e_st = 0, e_flush = 0;
  logic [4:0]    e_rf_rd = '0;
  logic [VW-1:0] e_rf_val = '0;
  int            e_rf_tag = 0, e_st_tag = 0;
  logic [AW-1:0] e_pc = '0;
  int tests = 0;
  int fails = 0;

  task automatic model_edge();
    bit   cm;
    ent_t h, e;
    e_rf_en = 0; e_st = 0; e_flush = 0;
    if (rst_in || (rdy_in && m_clr)) begin
      mq.delete(); m_next = 1; m_clr = 0; e_pc = '0;
      return;
    end
    if (!rdy_in) return;
    cm = (mq.size() > 0) && mq[0].rdy;
    if (cm) h = mq[0];
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      if (rs_cdbReady && rs_cdb2lab == TW'(e.tag)) begin e.rdy = 1; e.val = rs_cdb2val; end
      if (lsb_cdbReady && lsb_cdb2lab == TW'(e.tag)) begin e.rdy = 1; e.val = lsb_cdb2val; end
      mq[i] = e;
    end
    if (dec2rob_en && mq.size() < N) begin
      e = '{tag: m_next, rdy: 0, val: '0, op: op_type, rd: rd, pc: nowPC, jmp: jumpAddr, pred: predTaken};
      mq.push_back(e);
      m_next = m_next % N + 1;
    end
    if (cm) begin
      void'(mq.pop_front());
      if (h.op == OP_BR) begin
        if (h.val[0] != h.pred) begin
          e_flush = 1; m_clr = 1;
          e_pc = h.val[0] ? h.jmp : h.pc + 4;
        end
      end else if (h.op == OP_ST) begin
        e_st = 1; e_st_tag = h.tag;
      end else begin
        e_rf_en = 1; e_rf_rd = h.rd; e_rf_val = h.val; e_rf_tag = h.tag;
      end
    end
  endtask

  function automatic void m_resolve(input logic [TW-1:0] lab, input logic [VW-1:0] rv,
                                    output bit r, output logic [VW-1:0] v);
    r = 1; v = rv;
    if (lab == '0) return;
    foreach (mq[i]) if (TW'(mq[i].tag) == lab && mq[i].rdy) begin v = mq[i].val; return; end
    if (rs_cdbReady && rs_cdb2lab == lab) begin v = rs_cdb2val; return; end
    if (lsb_cdbReady && lsb_cdb2lab == lab) begin v = lsb_cdb2val; return; end
    r = 0; v = '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    rdy_in = 1; dec2rob_en = 0; op_type = OP_ALU; rd = '0; nowPC = '0; jumpAddr = '0;
    predTaken = 0; rf_lab1 = '0; rf_lab2 = '0; rf_val1 = '0; rf_val2 = '0;
    rs_cdbReady = 0; lsb_cdbReady = 0; rs_cdb2lab = '0; lsb_cdb2lab = '0;
    rs_cdb2val = '0; lsb_cdb2val = '0;
  endtask

  task automatic set_issue(input logic [OW-1:0] op, input logic [4:0] d,
                           input logic [AW-1:0] pc, input logic [AW-1:0] jmp, input logic p);
    dec2rob_en = 1; op_type = op; rd = d; nowPC = pc; jumpAddr = jmp; predTaken = p;
  endtask

  task automatic do_reset();
    set_idle(); rst_in = 1; tick(); tick(); rst_in = 0; #2;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (newTag !== TW'(m_next)) begin fails++; $display("FAIL reset_newTag: got %0d expected %0d", newTag, m_next); end
    tests++; if (isFull !== 1'b0) begin fails++; $display("FAIL reset_isFull: got %0b expected 0", isFull); end
    tests++; if (rob2rf_en !== e_rf_en || rob2lsb_store !== e_st) begin fails++; $display("FAIL reset_pulses: got rf_en=%0b st=%0b expected 0", rob2rf_en, rob2lsb_store); end
    tests++; if (flush !== e_flush || rob2if_pc !== e_pc) begin fails++; $display("FAIL reset_flush: got flush=%0b pc=%0h expected 0/0", flush, rob2if_pc); end
  endtask

  task automatic test_in_order();
    for (int i = 1; i <= 3; i++) begin
      set_idle(); set_issue(OP_ALU, 5'(i), 32'h0, 32'h0, 0); #2;
      tests++; if (newTag !== TW'(m_next)) begin fails++; $display("FAIL in_order_tag%0d: got %0d expected %0d", i, newTag, m_next); end
      tests++; if (isFull !== 1'b0) begin fails++; $display("FAIL in_order_full%0d: got %0b expected 0", i, isFull); end
      tick();
    end
    set_idle(); tick(); tick();
    tests++; if (rob2rf_en !== e_rf_en) begin fails++; $display("FAIL in_order_nocommit: got %0b expected %0b", rob2rf_en, e_rf_en); end
    rs_cdbReady = 1; rs_cdb2lab = 4'd2; rs_cdb2val = 32'h55; tick();
    set_idle(); lsb_cdbReady = 1; lsb_cdb2lab = 4'd1; lsb_cdb2val = 32'h11; tick();
    tests++; if (rob2rf_en !== e_rf_en) begin fails++; $display("FAIL in_order_early: got %0b expected %0b", rob2rf_en, e_rf_en); end
    set_idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (rob2rf_en !== e_rf_en || (e_rf_en && (rob2rf_rd !== e_rf_rd || rob2rf_val !== e_rf_val || rob2rf_tag !== TW'(e_rf_tag)))) begin
        fails++; $display("FAIL in_order_commit%0d: got en=%0b rd=%0d val=%0h tag=%0d expected en=%0b rd=%0d val=%0h tag=%0d",
                          k, rob2rf_en, rob2rf_rd, rob2rf_val, rob2rf_tag, e_rf_en, e_rf_rd, e_rf_val, e_rf_tag);
      end
    end
    rs_cdbReady = 1; rs_cdb2lab = 4'd3; rs_cdb2val = 32'h33; tick(); set_idle(); tick();
    tests++; if (rob2rf_en !== e_rf_en || rob2rf_tag !== TW'(e_rf_tag)) begin fails++; $display("FAIL in_order_tag3: got en=%0b tag=%0d expected en=%0b tag=%0d", rob2rf_en, rob2rf_tag, e_rf_en, e_rf_tag); end
  endtask

  task automatic test_forward();
    bit r; logic [VW-1:0] v;
    set_idle(); set_issue(OP_ALU, 5'd4, 32'h0, 32'h0, 0); tick();
    set_idle(); set_issue(OP_ALU, 5'd5, 32'h0, 32'h0, 0);
    rf_lab1 = TW'(mq[0].tag); rf_lab2 = '0; rf_val2 = 32'h1234;
    rs_cdbReady = 1; rs_cdb2lab = TW'(mq[0].tag); rs_cdb2val = 32'hAB; #2;
    m_resolve(rf_lab1, rf_val1, r, v);
    tests++; if (ready1 !== r || res1 !== v || label1 !== rf_lab1) begin fails++; $display("FAIL fwd_cdb: got rdy=%0b res=%0h lab=%0d expected rdy=%0b res=%0h", ready1, res1, label1, r, v); end
    m_resolve(rf_lab2, rf_val2, r, v);
    tests++; if (ready2 !== r || res2 !== v) begin fails++; $display("FAIL fwd_rf: got rdy=%0b res=%0h expected rdy=%0b res=%0h", ready2, res2, r, v); end
    tick();
    set_idle(); rf_lab1 = TW'(mq[0].tag); rf_lab2 = TW'(mq[1].tag); rf_val2 = 32'h77; #2;
    m_resolve(rf_lab1, rf_val1, r, v);
    tests++; if (ready1 !== r || res1 !== v) begin fails++; $display("FAIL fwd_entry: got rdy=%0b res=%0h expected rdy=%0b res=%0h", ready1, res1, r, v); end
    m_resolve(rf_lab2, rf_val2, r, v);
    tests++; if (ready2 !== r || res2 !== v || label2 !== rf_lab2) begin fails++; $display("FAIL fwd_pending: got rdy=%0b res=%0h expected rdy=%0b res=%0h", ready2, res2, r, v); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_idle(); set_issue(OP_ALU, 5'(i + 1), 32'h0, 32'h0, 0); #2;
      tests++; if (newTag !== TW'(m_next)) begin fails++; $display("FAIL fill_tag%0d: got %0d expected %0d", i, newTag, m_next); end
      tick();
    end
    #2;
    tests++; if (isFull !== (mq.size() == N)) begin fails++; $display("FAIL fill_full: got %0b expected %0b", isFull, mq.size() == N); end
    tick();
    tests++; if (isFull !== (mq.size() == N) || newTag !== TW'(m_next)) begin fails++; $display("FAIL fill_ninth: got full=%0b tag=%0d expected full=%0b tag=%0d", isFull, newTag, mq.size() == N, m_next); end
    set_idle(); lsb_cdbReady = 1; lsb_cdb2lab = 4'd1; lsb_cdb2val = 32'h9; tick();
    set_idle(); tick();
    tests++; if (rob2rf_en !== e_rf_en || rob2rf_tag !== TW'(e_rf_tag)) begin fails++; $display("FAIL wrap_commit: got en=%0b tag=%0d expected en=%0b tag=%0d", rob2rf_en, rob2rf_tag, e_rf_en, e_rf_tag); end
    set_issue(OP_ALU, 5'd9, 32'h0, 32'h0, 0); #2;
    tests++; if (isFull !== 1'b0 || newTag !== TW'(m_next)) begin fails++; $display("FAIL wrap_tag: got full=%0b tag=%0d expected full=0 tag=%0d", isFull, newTag, m_next); end
    tick(); set_idle(); #2;
    tests++; if (isFull !== (mq.size() == N)) begin fails++; $display("FAIL wrap_refill: got %0b expected %0b", isFull, mq.size() == N); end
  endtask

  task automatic test_branch();
    do_reset();
    set_issue(OP_BR, 5'd0, 32'h100, 32'h200, 0); tick();
    set_idle(); rs_cdbReady = 1; rs_cdb2lab = 4'd1; rs_cdb2val = 32'h1; tick();
    set_idle(); tick();
    tests++; if (flush !== e_flush || rob2if_pc !== e_pc) begin fails++; $display("FAIL br_flush: got flush=%0b pc=%0h expected flush=%0b pc=%0h", flush, rob2if_pc, e_flush, e_pc); end
    tests++; if (rob2rf_en !== e_rf_en) begin fails++; $display("FAIL br_rf: got %0b expected %0b", rob2rf_en, e_rf_en); end
    set_issue(OP_ALU, 5'd3, 32'h0, 32'h0, 0); tick(); set_idle(); #2;
    tests++; if (flush !== e_flush || newTag !== TW'(m_next) || isFull !== 1'b0) begin fails++; $display("FAIL br_clear: got flush=%0b tag=%0d full=%0b expected flush=%0b tag=%0d", flush, newTag, isFull, e_flush, m_next); end
    tests++; if (rob2if_pc !== e_pc) begin fails++; $display("FAIL br_pc_clear: got %0h expected %0h", rob2if_pc, e_pc); end
  endtask

  task automatic test_store();
    do_reset();
    set_issue(OP_ALU, 5'd1, 32'h0, 32'h0, 0); tick();
    set_issue(OP_ST, 5'd0, 32'h0, 32'h0, 0); tick();
    set_idle(); rs_cdbReady = 1; rs_cdb2lab = 4'd1; lsb_cdbReady = 1; lsb_cdb2lab = 4'd2; lsb_cdb2val = 32'hC; tick();
    set_idle(); tick(); tick();
    tests++; if (rob2lsb_store !== e_st || rob2lsb_tag !== TW'(e_st_tag) || rob2rf_en !== e_rf_en) begin
      fails++; $display("FAIL store_commit: got st=%0b tag=%0d rf_en=%0b expected st=%0b tag=%0d rf_en=%0b", rob2lsb_store, rob2lsb_tag, rob2rf_en, e_st, e_st_tag, e_rf_en);
    end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    set_issue(OP_ALU, 5'd6, 32'h0, 32'h0, 0); tick();
    rdy_in = 0; rs_cdbReady = 1; rs_cdb2lab = 4'd1; rs_cdb2val = 32'h66; tick();
    tests++; if (newTag !== TW'(m_next)) begin fails++; $display("FAIL hold_tag: got %0d expected %0d", newTag, m_next); end
    set_idle(); tick(); tick();
    tests++; if (rob2rf_en !== e_rf_en) begin fails++; $display("FAIL hold_commit: got %0b expected %0b", rob2rf_en, e_rf_en); end
  endtask

  task automatic test_random();
    bit r; logic [VW-1:0] v;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: set_issue(OP_ALU, 5'($urandom), AW'($urandom) & ~32'h3, AW'($urandom) & ~32'h3, 1'($urandom));
        1: set_issue(OP_BR, 5'($urandom), AW'($urandom) & ~32'h3, AW'($urandom) & ~32'h3, 1'($urandom));
        2: set_issue(OP_ST, 5'($urandom), AW'($urandom) & ~32'h3, AW'($urandom) & ~32'h3, 1'($urandom));
        default: set_idle();
      endcase
      rf_val1 = $urandom; rf_val2 = $urandom;
      if (mq.size() > 0) begin
        if ($urandom_range(0, 1) != 0) rf_lab1 = TW'(mq[$urandom_range(0, mq.size() - 1)].tag);
        if ($urandom_range(0, 1) != 0) rf_lab2 = TW'(mq[$urandom_range(0, mq.size() - 1)].tag);
        if ($urandom_range(0, 2) != 0) begin rs_cdbReady = 1; rs_cdb2lab = TW'(mq[$urandom_range(0, mq.size() - 1)].tag); rs_cdb2val = $urandom; end
        if ($urandom_range(0, 2) != 0) begin lsb_cdbReady = 1; lsb_cdb2lab = TW'(mq[$urandom_range(0, mq.size() - 1)].tag); lsb_cdb2val = $urandom; end
      end
      #2;
      tests++; if (newTag !== TW'(m_next) || isFull !== (mq.size() == N)) begin fails++; $display("FAIL rnd_alloc c%0d: got tag=%0d full=%0b expected tag=%0d full=%0b", c, newTag, isFull, m_next, mq.size() == N); end
      m_resolve(rf_lab1, rf_val1, r, v);
      tests++; if (ready1 !== r || res1 !== v || label1 !== rf_lab1) begin fails++; $display("FAIL rnd_op1 c%0d: got rdy=%0b res=%0h expected rdy=%0b res=%0h", c, ready1, res1, r, v); end
      m_resolve(rf_lab2, rf_val2, r, v);
      tests++; if (ready2 !== r || res2 !== v || label2 !== rf_lab2) begin fails++; $display("FAIL rnd_op2 c%0d: got rdy=%0b res=%0h expected rdy=%0b res=%0h", c, ready2, res2, r, v); end
      tick();
      tests++;
      if (rob2rf_en !== e_rf_en || (e_rf_en && (rob2rf_rd !== e_rf_rd || rob2rf_val !== e_rf_val || rob2rf_tag !== TW'(e_rf_tag)))) begin
        fails++; $display("FAIL rnd_rf c%0d: got en=%0b rd=%0d val=%0h tag=%0d expected en=%0b rd=%0d val=%0h tag=%0d",
                          c, rob2rf_en, rob2rf_rd, rob2rf_val, rob2rf_tag, e_rf_en, e_rf_rd, e_rf_val, e_rf_tag);
      end
      tests++; if (rob2lsb_store !== e_st || (e_st && rob2lsb_tag !== TW'(e_st_tag))) begin fails++; $display("FAIL rnd_st c%0d: got st=%0b tag=%0d expected st=%0b tag=%0d", c, rob2lsb_store, rob2lsb_tag, e_st, e_st_tag); end
      tests++; if (flush !== e_flush || rob2if_pc !== e_pc) begin fails++; $display("FAIL rnd_flush c%0d: got flush=%0b pc=%0h expected flush=%0b pc=%0h", c, flush, rob2if_pc, e_flush, e_pc); end
    end
  endtask

  initial begin
    rst_in = 1;
    set_idle();
    test_reset();
    test_in_order();
    test_forward();
    test_full_wrap();
    test_branch();
    test_store();
    test_rdy_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order completion buffer that allocates the ROB tags consumed by the reservation station and load/store buffer, supplies operand labels/values/readiness at issue, snoops both CDB broadcast ports, and retires results in program order to the register file and store path. Sits between decoder/regFile (issue side) and the RS/LSB CDB outputs (completion side); it is the sole source of `flush` and the redirect PC on branch mispredict.

## Interface
- `ROB_SIZE`, 8, entry count; equals 2^`ROB_ID_WIDTH`. Tags are `ROB_ID_WIDTH+1` bits; tag = slot index + 1, tag 0 = "no label".
- Widths `ROB_ID_WIDTH`, `VAL_WIDTH`, `ADDR_WIDTH`, `OP_WIDTH` come from util.v.

Ports:
- `clk` in 1: sole clock, all state updates on posedge.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: low = hold all state, no issue/commit/flush.
- `dec2rob_en` in 1: issue request, one instruction.
- `type` in `OP_WIDTH`: opcode class; identifies branch, store, register-writing ops.
- `rd` in 5: destination register (0 = none).
- `nowPC` in `ADDR_WIDTH`: PC of issuing instruction.
- `jumpAddr` in `ADDR_WIDTH`: branch target computed at decode.
- `predTaken` in 1: fetch prediction for branches.
- `rf_lab1`, `rf_lab2` in `ROB_ID_WIDTH+1`: producer tags from regFile (0 = committed value).
- `rf_val1`, `rf_val2` in `VAL_WIDTH`: regFile values.
- `label1`, `label2` out `ROB_ID_WIDTH+1`: forwarded `rf_lab*`.
- `res1`, `res2` out `VAL_WIDTH`; `ready1`, `ready2` out 1: operand resolution (combinational).
- `newTag` out `ROB_ID_WIDTH+1`: tag assigned to the issuing instruction (tail+1).
- `isFull` out 1: no free entry.
- `rs_cdbReady`, `lsb_cdbReady` in 1; `rs_cdb2lab`, `lsb_cdb2lab` in `ROB_ID_WIDTH+1`; `rs_cdb2val`, `lsb_cdb2val` in `VAL_WIDTH`: completion broadcasts.
- `rob2rf_en` out 1; `rob2rf_rd` out 5; `rob2rf_val` out `VAL_WIDTH`; `rob2rf_tag` out `ROB_ID_WIDTH+1`: register commit.
- `rob2lsb_store` out 1; `rob2lsb_tag` out `ROB_ID_WIDTH+1`: store commit permission.
- `flush` out 1; `rob2if_pc` out `ADDR_WIDTH`: mispredict redirect.

## Operation
- Entry fields: busy, ready, type, rd, val, pc, jumpAddr, predTaken. Pointers head, tail (`ROB_ID_WIDTH` bits, wrap naturally), count (`ROB_ID_WIDTH+1` bits).
- Issue: when `dec2rob_en && !isFull && rdy_in`, slot tail filled, busy=1, ready=0, tail+=1. `newTag` = tail+1 driven combinationally before the edge.
- Operand resolve (per operand n): `label_n`=`rf_lab_n`. If 0: ready=1, res=`rf_val_n`. Else if entry ready: ready=1, res=entry val. Else if CDB (either port) carries that tag this cycle: ready=1, res=CDB val (RS port priority). Else ready=0, res=0.
- Completion: each valid CDB port with nonzero tag matching a busy entry sets ready=1, val=CDB val. Both ports may hit different entries in one cycle.
- Branch entries: CDB val bit0 = actual taken.
- Commit: at most one per cycle, when head busy and ready (registered state only). Register ops: `rob2rf_en`=1 with rd/val/tag (rd=0 still pulses with rd=0). Stores: `rob2lsb_store`=1 with tag. Branch: if actual != predTaken, `flush`=1, `rob2if_pc` = actual ? jumpAddr : pc+4. Head+=1, entry busy cleared.
- Flush: the cycle after `flush` pulses, all entries cleared, head=tail=count=0; issue in that cycle ignored.
- count updates by +issue −commit; simultaneous issue and commit when full is not allowed (full blocks issue).

## Timing
- Reset (and flush-clear): all busy/ready 0, pointers 0; `rob2rf_en`, `rob2lsb_store`, `flush` 0, `rob2if_pc` 0, `isFull` 0, `newTag` 1.
- Commit outputs registered, one-cycle pulses. Min latency CDB broadcast → commit of that entry: 1 cycle (ready captured at edge N, commit outputs valid after edge N+1).
- `isFull`, `newTag`, `label/res/ready` combinational from current state/inputs.
- `rdy_in` low: no state change, pulse outputs drop to 0.
- Wrap: tail/head at ROB_SIZE−1 wrap to 0; tag for slot 7 is 8.

## Test plan
- Reset, issue 3 ALU ops (rd=1,2,3) -> `newTag` 1,2,3; `isFull`=0; no commit until CDB.
- CDB tag 2 val 0x55 then tag 1 val 0x11 -> commits in order: rd1=0x11 then rd2=0x55 on consecutive cycles, tag 3 held.
- Issue with `rf_lab1`=2 while RS CDB broadcasts tag 2 val 0xAB same cycle -> `ready1`=1, `res1`=0xAB.
- Fill 8 entries -> `isFull`=1, 9th `dec2rob_en` ignored; commit one -> next issue gets tag 1 (wrap).
- Branch pc 0x100, jumpAddr 0x200, predTaken 0, CDB val 1 -> `flush`=1, `rob2if_pc`=0x200, next cycle ROB empty, `newTag`=1.
- Store entry completes via LSB CDB -> `rob2lsb_store`=1 with its tag, `rob2rf_en`=0.
